mar_burst: RTL and testbench

- Parametrised memory address register that supersedes the fixed 15-bit two-input MAR.
- Loads an address from one of two sources and drives it to memory.
- Adds an autonomous burst engine: N sequential address beats, handshaked against memory, with linear or wrapping increment.
- Sits between the control unit and the memory port. Control issues load/start; memory acknowledges each beat.

---
 rtl/mar_pkg.sv | 15 +
 rtl/mar_addr_inc.sv | 28 ++
 rtl/mar_burst.sv | 107 ++++++++++
 tb/tb_mar_burst.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mar_pkg.sv
// Shared definitions for the memory address register with burst engine.
//   MAR_AW      : default address width (bits)
//   MAR_BW      : default burst-length field width (bits); also sets the wrap block size
//   mar_state_e : burst engine state (IDLE, BURST)
package mar_pkg;

  localparam int MAR_AW = 15;
  localparam int MAR_BW = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } mar_state_e;

endpackage

// File: rtl/mar_addr_inc.sv
// Combinational next-address generator for the burst engine.
//   addr : current address (AW bits)
//   wrap : 0 = linear increment modulo 2^AW,
//          1 = increment the low BW bits only, staying inside the aligned 2^BW block
//   next : address of the following beat (AW bits)
// BW must be smaller than AW so that an upper block-index field exists.
module mar_addr_inc
  import mar_pkg::*;
#(
  parameter int AW = MAR_AW,
  parameter int BW = MAR_BW
) (
  input  logic [AW-1:0] addr,
  input  logic          wrap,
  output logic [AW-1:0] next
);

  logic [BW-1:0] low_inc;

  always_comb begin
    low_inc = addr[BW-1:0] + BW'(1);
    next    = addr + AW'(1);
    if (wrap) begin
      next = {addr[AW-1:BW], low_inc};
    end
  end

endmodule

// File: rtl/mar_burst.sv
// Memory address register with an autonomous burst engine.
//   clk, rst  : clock; synchronous active-high reset
//   in1, in2  : address sources, chosen by sel (0 = in1, 1 = in2)
//   we        : load the address register from the selected source (idle only)
//   re        : start a burst of len+1 beats (idle only); wrap picks the increment mode
//   mem_ack   : memory accepted the beat currently on out1
//   out1      : current address; valid as a beat while mem_req is high
//   mem_req   : beat request
//   busy      : burst in progress
//   done      : one-cycle pulse once the last beat has been accepted
// All outputs come straight from flops; no input reaches an output combinationally.
module mar_burst
  import mar_pkg::*;
#(
  parameter int AW = MAR_AW,
  parameter int BW = MAR_BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] in1,
  input  logic [AW-1:0] in2,
  input  logic          sel,
  input  logic          we,
  input  logic          re,
  input  logic [BW-1:0] len,
  input  logic          wrap,
  input  logic          mem_ack,
  output logic [AW-1:0] out1,
  output logic          mem_req,
  output logic          busy,
  output logic          done
);

  mar_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic [AW-1:0] addr_next;

  mar_addr_inc #(
    .AW (AW),
    .BW (BW)
  ) u_inc (
    .addr (addr_q),
    .wrap (wrap_q),
    .next (addr_next)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A simultaneous load and start makes the burst begin at the freshly
        // loaded address, since the load lands on the same edge.
        if (we) begin
          addr_d = sel ? in2 : in1;
        end
        if (re) begin
          cnt_d   = len;
          wrap_d  = wrap;
          state_d = BURST;
        end
      end
      BURST: begin
        // cnt_q holds the beats remaining after the current one; the beat
        // accepted with cnt_q == 0 is the last.
        if (mem_ack) begin
          addr_d = addr_next;
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign out1    = addr_q;
  assign mem_req = (state_q == BURST);
  assign busy    = (state_q == BURST);
  assign done    = done_q;

endmodule

// File: tb/tb_mar_burst.sv
module tb_mar_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] in1, in2;
  logic        sel, we, re, wrap, mem_ack;
  logic [3:0]  len;
  logic [14:0] out1;
  logic        mem_req, busy, done;

  mar_burst #(.AW(15), .BW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .in1     (in1),
    .in2     (in2),
    .sel     (sel),
    .we      (we),
    .re      (re),
    .len     (len),
    .wrap    (wrap),
    .mem_ack (mem_ack),
    .out1    (out1),
    .mem_req (mem_req),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Address of beat i of a burst starting at b: plain offset arithmetic.
  function automatic logic [14:0] beat_addr(logic [14:0] b, int i, logic w);
    logic [14:0] lin;
    logic [3:0]  lo;
    lin = b + 15'(i);
    lo  = b[3:0] + 4'(i);
    return w ? {b[14:4], lo} : lin;
  endfunction

  // Reference model: when a burst starts, the whole list of beat addresses
  // (plus the post-burst address) is precomputed; acks just walk the list.
  logic        m_valid = 1'b0;
  logic [14:0] m_out;
  logic        m_busy, m_done;
  logic [14:0] m_beats [0:16];
  int          m_n, m_idx;

  always @(posedge clk) begin
    logic [14:0] base;
    int          n;
    if (rst) begin
      m_valid <= 1'b1;
      m_out   <= '0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_idx   <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        base = we ? (sel ? in2 : in1) : m_out;
        m_out <= base;
        if (re) begin
          n = int'(len) + 1;
          for (int i = 0; i <= n; i++) m_beats[i] <= beat_addr(base, i, wrap);
          m_n    <= n;
          m_idx  <= 0;
          m_busy <= 1'b1;
        end
      end else if (mem_ack) begin
        m_out <= m_beats[m_idx+1];
        m_idx <= m_idx + 1;
        if (m_idx + 1 == m_n) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus a log of accepted beats.
  int          m_total = 0, m_pass = 0;
  int          done_cnt = 0;
  logic [14:0] obs [$];

  always @(negedge clk) begin
    if (m_valid) begin
      m_total += 4;
      if (out1 === m_out) m_pass++;
      else $display("FAIL model_out1 got %h exp %h at %0t", out1, m_out, $time);
      if (mem_req === m_busy) m_pass++;
      else $display("FAIL model_mem_req got %b exp %b at %0t", mem_req, m_busy, $time);
      if (busy === m_busy) m_pass++;
      else $display("FAIL model_busy got %b exp %b at %0t", busy, m_busy, $time);
      if (done === m_done) m_pass++;
      else $display("FAIL model_done got %b exp %b at %0t", done, m_done, $time);
      if (mem_req === 1'b1 && mem_ack === 1'b1) obs.push_back(out1);
      if (done === 1'b1) done_cnt++;
    end
  end

  // Hand-computed literal expectations.
  int lit_total = 0, lit_pass = 0;

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    lit_total++;
    if (got === exp) lit_pass++;
    else $display("FAIL %s got %h exp %h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beats(input string nm, input int start, input int n,
                             input logic [14:0] e0, input logic [14:0] e1,
                             input logic [14:0] e2, input logic [14:0] e3);
    logic [14:0] e [4];
    e = '{e0, e1, e2, e3};
    lit({nm, "_count"}, 32'(obs.size() - start), 32'(n));
    for (int i = 0; i < n && start + i < obs.size(); i++)
      lit($sformatf("%s_beat%0d", nm, i), 32'(obs[start+i]), 32'(e[i]));
  endtask

  task automatic wait_done(input string nm, input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (done === 1'b1) break;
    end
    lit({nm, "_done_seen"}, 32'(done), 32'd1);
  endtask

  // Load base, then start a burst with mem_ack held high.
  task automatic burst(input string nm, input logic [14:0] base, input logic [3:0] l,
                       input logic w, output int start, output int dc);
    sel = 1'b0; in1 = base; we = 1'b1;
    tick();
    we = 1'b0; mem_ack = 1'b1;
    start = obs.size(); dc = done_cnt;
    re = 1'b1; len = l; wrap = w;
    tick();
    re = 1'b0;
    wait_done(nm, 40);
  endtask

  int st, dc;

  initial begin
    rst = 1'b1; in1 = '0; in2 = '0; sel = 1'b0; we = 1'b0; re = 1'b0;
    len = '0; wrap = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    lit("reset_out1", 32'(out1), 32'h0);
    lit("reset_busy", 32'(busy), 32'h0);
    lit("reset_done", 32'(done), 32'h0);
    tick();

    // Loads from both sources; a stray ack in idle is ignored.
    mem_ack = 1'b1;
    sel = 1'b0; in1 = 15'h1234; we = 1'b1;
    tick();
    we = 1'b0;
    lit("load_in1_out1", 32'(out1), 32'h1234);
    lit("load_in1_mem_req", 32'(mem_req), 32'h0);
    sel = 1'b1; in2 = 15'h0042; we = 1'b1;
    tick();
    we = 1'b0;
    lit("load_in2_out1", 32'(out1), 32'h0042);
    tick();
    lit("idle_ack_hold", 32'(out1), 32'h0042);

    // Linear burst of four.
    burst("linear", 15'h0010, 4'd3, 1'b0, st, dc);
    lit("linear_final", 32'(out1), 32'h0014);
    lit("linear_busy", 32'(busy), 32'h0);
    check_beats("linear", st, 4, 15'h0010, 15'h0011, 15'h0012, 15'h0013);
    tick();
    lit("linear_one_done", 32'(done_cnt - dc), 32'd1);

    // Wrap within the aligned 16-word block.
    burst("wrap", 15'h001E, 4'd3, 1'b1, st, dc);
    lit("wrap_final", 32'(out1), 32'h0012);
    check_beats("wrap", st, 4, 15'h001E, 15'h001F, 15'h0010, 15'h0011);

    // Linear rollover at the top of the address space.
    burst("ovf", 15'h7FFF, 4'd1, 1'b0, st, dc);
    lit("ovf_final", 32'(out1), 32'h0001);
    check_beats("ovf", st, 2, 15'h7FFF, 15'h0000, 15'h0, 15'h0);
    tick();

    // Stalls, and a load attempt mid-burst.
    mem_ack = 1'b0; sel = 1'b0; in1 = 15'h0200; we = 1'b1;
    tick();
    we = 1'b0; st = obs.size();
    re = 1'b1; len = 4'd2; wrap = 1'b0;
    tick();
    re = 1'b0;
    mem_ack = 1'b1; tick();
    mem_ack = 1'b0; tick();
    lit("stall_hold_a", 32'(out1), 32'h0201);
    mem_ack = 1'b0; we = 1'b1; in1 = 15'h0555; tick();
    we = 1'b0;
    lit("stall_hold_b", 32'(out1), 32'h0201);
    lit("stall_busy", 32'(busy), 32'h1);
    mem_ack = 1'b1; tick();
    lit("stall_not_done", 32'(done), 32'h0);
    mem_ack = 1'b1; tick();
    lit("stall_done", 32'(done), 32'h1);
    lit("stall_final", 32'(out1), 32'h0203);
    check_beats("stall", st, 3, 15'h0200, 15'h0201, 15'h0202, 15'h0);

    // Load and start on the same edge.
    tick();
    st = obs.size();
    we = 1'b1; re = 1'b1; sel = 1'b0; in1 = 15'h0100; len = 4'd0; wrap = 1'b0; mem_ack = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    wait_done("loadgo", 40);
    lit("loadgo_final", 32'(out1), 32'h0101);
    check_beats("loadgo", st, 1, 15'h0100, 15'h0, 15'h0, 15'h0);

    // Reset during the second beat of an eight-beat burst.
    tick();
    sel = 1'b0; in1 = 15'h0300; we = 1'b1;
    tick();
    we = 1'b0; dc = done_cnt;
    re = 1'b1; len = 4'd7;
    tick();
    re = 1'b0;
    tick();
    lit("abort_second_beat", 32'(out1), 32'h0301);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lit("abort_out1", 32'(out1), 32'h0);
    lit("abort_mem_req", 32'(mem_req), 32'h0);
    lit("abort_busy", 32'(busy), 32'h0);
    lit("abort_done", 32'(done), 32'h0);
    tick(); tick();
    lit("abort_no_done", 32'(done_cnt - dc), 32'd0);
    st = obs.size();
    re = 1'b1; len = 4'd0;
    tick();
    re = 1'b0;
    wait_done("restart", 40);
    lit("restart_final", 32'(out1), 32'h0001);
    check_beats("restart", st, 1, 15'h0000, 15'h0, 15'h0, 15'h0);
    tick(); tick();

    $display("%0d/%0d checks passed", m_pass + lit_pass, m_total + lit_total);
    $finish;
  end

endmodule
